booth_product_accumulator: RTL and testbench

Downstream consumer of the pipelined Booth multiplier. It tags the multiplier's free-running `product` stream with a delayed copy of the operand-valid strobe and sums FRAME_LEN valid products into a signed accumulator. It then presents each frame total through a one-deep valid/ready output register. It turns the fixed-latency, non-stallable multiplier into a framed multiply-accumulate stage for the next block in the datapath.

---
 rtl/booth_acc_pkg.sv | 37 +++
 rtl/booth_valid_delay.sv | 25 ++
 rtl/booth_product_accumulator.sv | 147 ++++++++++++++
 tb/tb_booth_product_accumulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_acc_pkg.sv
// Shared types and helpers for the Booth product accumulator and related fixed-latency stages.
package booth_acc_pkg;

    localparam int unsigned DEF_PROD_W = 16;
    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned MAX_ACC_W  = 64;

    typedef enum logic [0:0] {
        ACCUM = 1'b0
    } acc_state_t;

    // Sign-extend the low w bits of v to MAX_ACC_W+1 bits.
    function automatic logic [MAX_ACC_W:0] sext(input logic [MAX_ACC_W-1:0] v,
                                                 input int unsigned         w);
        logic [MAX_ACC_W:0] m;
        logic [MAX_ACC_W:0] x;
        m = {(MAX_ACC_W+1){1'b1}} << w;
        x = {1'b0, v};
        return v[w-1] ? (x | m) : (x & ~m);
    endfunction

    // Clamp a true (sign-extended) sum to the acc_w-bit signed range when ovf is set.
    function automatic logic [MAX_ACC_W-1:0] sat_acc(input logic [MAX_ACC_W:0] sum,
                                                     input logic               ovf,
                                                     input int unsigned        acc_w);
        logic [MAX_ACC_W-1:0] lim;
        lim = (MAX_ACC_W'(1) << (acc_w - 1)) - MAX_ACC_W'(1);
        if (!ovf) begin
            return sum[MAX_ACC_W-1:0];
        end else if (sum[MAX_ACC_W]) begin
            return ~lim;
        end else begin
            return lim;
        end
    endfunction

endpackage

// File: rtl/booth_valid_delay.sv
// Fixed-depth 1-bit valid delay line with synchronous active-low reset and synchronous clear.
module booth_valid_delay #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_in,
    output logic o_out
);

    logic [DEPTH-1:0] r_sr;

    // Truncating cast drops the oldest bit, so this also works for DEPTH=1.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_sr <= '0;
        end else begin
            r_sr <= DEPTH'({r_sr, i_in});
        end
    end

    assign o_out = r_sr[DEPTH-1];

endmodule

// File: rtl/booth_product_accumulator.sv
// Framed multiply-accumulate stage behind a fixed-latency Booth multiplier.
// Build option: BOOTH_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module booth_product_accumulator
    import booth_acc_pkg::*;
#(
    parameter int unsigned PROD_W    = DEF_PROD_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned MUL_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              acc_ovf,
    output logic              frame_lost
);

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf_s;
    logic             w_ovf_s_nxt;

    logic [ACC_W-1:0] r_acc_data;
    logic             r_acc_valid;
    logic             r_acc_ovf;
    logic             r_frame_lost;

    logic             w_pv;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic             w_ovf_final;
    logic [ACC_W-1:0] w_acc_upd;
    logic             w_done;
    logic             w_out_free;

    booth_valid_delay #(
        .DEPTH (MUL_LAT)
    ) u_valid_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_in    (op_valid),
        .o_out   (w_pv)
    );

    // One guard bit on the sum exposes signed overflow of the ACC_W accumulator.
    assign w_prod_ext  = (ACC_W+1)'(sext(MAX_ACC_W'(product), PROD_W));
    assign w_sum       = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_ovf       = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_ovf_final = r_ovf_s | w_ovf;

`ifdef BOOTH_ACC_SATURATE_EN
    assign w_acc_upd = ACC_W'(sat_acc(sext(MAX_ACC_W'(w_sum), ACC_W + 1), w_ovf, ACC_W));
`else
    assign w_acc_upd = w_sum[ACC_W-1:0];
`endif

    assign w_out_free = !r_acc_valid || acc_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf_s <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf_s <= w_ovf_s_nxt;
        end
    end

    // Next-state and frame bookkeeping; clear wins over a simultaneous valid product.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_s_nxt = r_ovf_s;
        w_done      = 1'b0;
        case (r_state)
            ACCUM: begin
                if (clear) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_s_nxt = 1'b0;
                end else if (w_pv) begin
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_done      = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_s_nxt = 1'b0;
                    end else begin
                        w_acc_nxt   = w_acc_upd;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_ovf_s_nxt = w_ovf_final;
                    end
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // One-deep output register; a completed frame that finds it occupied is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_data   <= '0;
            r_acc_valid  <= 1'b0;
            r_acc_ovf    <= 1'b0;
            r_frame_lost <= 1'b0;
        end else begin
            r_frame_lost <= 1'b0;
            if (w_done && w_out_free) begin
                r_acc_data  <= w_acc_upd;
                r_acc_ovf   <= w_ovf_final;
                r_acc_valid <= 1'b1;
            end else begin
                if (w_done) begin
                    r_frame_lost <= 1'b1;
                end
                if (r_acc_valid && acc_ready) begin
                    r_acc_valid <= 1'b0;
                end
            end
        end
    end

    assign acc_data   = r_acc_data;
    assign acc_valid  = r_acc_valid;
    assign acc_ovf    = r_acc_ovf;
    assign frame_lost = r_frame_lost;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: behavioural multiplier + frame model, per-cycle compare,
// and directed scenarios with hand-computed totals.
module tb_booth_product_accumulator;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W     = 16;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned MUL_LAT   = 4;
    localparam int          MAXV      = 32767;
    localparam int          MINV      = -32768;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              op_valid = 1'b0;
    logic              clear = 1'b0;
    logic              acc_ready = 1'b0;
    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_valid;
    logic              acc_ovf;
    logic              frame_lost;

    int a_op = 0;
    int b_op = 0;

    int checks = 0;
    int failures = 0;

    booth_product_accumulator #(
        .PROD_W    (PROD_W),
        .ACC_W     (ACC_W),
        .FRAME_LEN (FRAME_LEN),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .product    (product),
        .clear      (clear),
        .acc_data   (acc_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_ovf    (acc_ovf),
        .frame_lost (frame_lost)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: fixed latency, free-running, junk on idle cycles.
    logic [PROD_W-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= op_valid ? PROD_W'(a_op * b_op) : PROD_W'($urandom);
        for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign product = mul_pipe[MUL_LAT-1];

    // Reference model: products due MUL_LAT cycles after issue, integer frame sums.
    typedef struct {
        int due;
        int val;
    } ent_t;
    ent_t             q[$];
    ent_t             ent;
    int               cyc = 0;
    int               m_acc = 0;
    int               m_cnt = 0;
    bit               m_ovf = 0;
    int               s;
    bit               o;
    bit               done;
    int               tot;
    bit               tovf;
    bit               hs;
    bit               started = 0;
    bit               e_valid = 0;
    bit               e_ovf = 0;
    bit               e_lost = 0;
    logic [ACC_W-1:0] e_data = '0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        e_lost = 0;
        done = 0;
        if (!rst_n) begin
            q.delete();
            m_acc = 0; m_cnt = 0; m_ovf = 0;
            e_valid = 0; e_data = '0; e_ovf = 0;
        end else begin
            hs = e_valid && acc_ready;
            if (clear) begin
                q.delete();
                m_acc = 0; m_cnt = 0; m_ovf = 0;
            end else begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    ent = q.pop_front();
                    s = m_acc + ent.val;
                    o = (s > MAXV) || (s < MINV);
`ifdef BOOTH_ACC_SATURATE_EN
                    if (o) s = (s > MAXV) ? MAXV : MINV;
`else
                    s = int'($signed(ACC_W'(s)));
`endif
                    tovf = m_ovf | o;
                    m_cnt++;
                    if (m_cnt == int'(FRAME_LEN)) begin
                        done = 1; tot = s;
                        m_acc = 0; m_cnt = 0; m_ovf = 0;
                    end else begin
                        m_acc = s; m_ovf = tovf;
                    end
                end
                if (op_valid) q.push_back('{cyc + int'(MUL_LAT), a_op * b_op});
            end
            if (done) begin
                if (!e_valid || acc_ready) begin
                    e_valid = 1; e_data = ACC_W'(tot); e_ovf = tovf;
                end else begin
                    e_lost = 1;
                end
            end else if (hs) begin
                e_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (acc_valid !== e_valid || acc_data !== e_data || acc_ovf !== e_ovf ||
                frame_lost !== e_lost) begin
                failures++;
                $display("FAIL cycle_model cyc=%0d got v=%b d=%h o=%b l=%b want v=%b d=%h o=%b l=%b",
                         cyc, acc_valid, acc_data, acc_ovf, frame_lost,
                         e_valid, e_data, e_ovf, e_lost);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input int b);
        op_valid = 1'b1; a_op = a; b_op = b;
        step();
        op_valid = 1'b0;
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!acc_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (!acc_valid) begin
            failures++;
            $display("FAIL %s_timeout got acc_valid=0 want 1 within 20 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000");
        $fatal(1, "watchdog");
    end

    int lat;
    int lost_cnt;
    int bad_cnt;
    int hs_cnt;
    int hs_data;

    initial begin
        step(); step(); step();
        check_eq("reset_valid", int'(acc_valid), 0);
        check_eq("reset_data", int'(acc_data), 0);
        check_eq("reset_ovf", int'(acc_ovf), 0);
        check_eq("reset_lost", int'(frame_lost), 0);
        rst_n = 1'b1;
        step();

        // Basic frame: 8 - 20 - 288 + 16129 = 15829
        acc_ready = 1'b1;
        issue(2, 4); issue(-4, 5); issue(36, -8); issue(-127, -127);
        wait_valid("basic", lat);
        check_eq("basic_latency", lat, 5);
        check_eq("basic_data", int'($signed(acc_data)), 15829);
        check_eq("basic_ovf", int'(acc_ovf), 0);
        step(); step();

        // Overflow: 4 * 16129 = 64516 exceeds 16-bit signed range
        repeat (4) issue(-127, -127);
        wait_valid("ovf", lat);
`ifdef BOOTH_ACC_SATURATE_EN
        check_eq("ovf_data", int'($signed(acc_data)), 32767);
`else
        check_eq("ovf_data", int'($signed(acc_data)), -1020);
`endif
        check_eq("ovf_flag", int'(acc_ovf), 1);
        step(); step();

        // Backpressure across two frames: totals 30 then 100 (dropped)
        acc_ready = 1'b0;
        issue(1, 1); issue(2, 2); issue(3, 3); issue(4, 4);
        repeat (4) issue(5, 5);
        lost_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (frame_lost) lost_cnt++;
            if (acc_valid && int'($signed(acc_data)) != 30) bad_cnt++;
        end
        check_eq("bp_lost_pulses", lost_cnt, 1);
        check_eq("bp_unstable_cycles", bad_cnt, 0);
        check_eq("bp_held_valid", int'(acc_valid), 1);
        acc_ready = 1'b1;
        hs_cnt = 0; hs_data = 0;
        for (int i = 0; i < 4; i++) begin
            if (acc_valid && acc_ready) begin
                hs_cnt++;
                hs_data = int'($signed(acc_data));
            end
            step();
        end
        check_eq("bp_handshakes", hs_cnt, 1);
        check_eq("bp_hs_data", hs_data, 30);
        check_eq("bp_drained", int'(acc_valid), 0);

        // Same-cycle free: frame 16 held, frame 36 loads as 16 is accepted
        acc_ready = 1'b0;
        repeat (4) issue(2, 2);
        repeat (4) issue(3, 3);
        step(); step(); step();
        check_eq("scf_prev_data", int'($signed(acc_data)), 16);
        acc_ready = 1'b1;
        step();
        check_eq("scf_new_data", int'($signed(acc_data)), 36);
        check_eq("scf_new_valid", int'(acc_valid), 1);
        check_eq("scf_lost", int'(frame_lost), 0);
        step(); step();

        // Clear mid-frame; op_valid in the clear cycle is ignored
        issue(7, 7); issue(9, 9);
        repeat (5) step();
        clear = 1'b1; op_valid = 1'b1; a_op = 50; b_op = 50;
        step();
        clear = 1'b0; op_valid = 1'b0;
        repeat (4) issue(1, 1);
        wait_valid("clr", lat);
        check_eq("clr_latency", lat, 5);
        check_eq("clr_data", int'($signed(acc_data)), 4);
        step(); step();

        // Reset with pending output and a partial frame in flight
        acc_ready = 1'b0;
        repeat (4) issue(1, 2);
        issue(1, 1); issue(1, 1);
        repeat (5) step();
        check_eq("rst_pending_before", int'(acc_valid), 1);
        rst_n = 1'b0;
        step();
        check_eq("rst_valid", int'(acc_valid), 0);
        check_eq("rst_data", int'(acc_data), 0);
        check_eq("rst_ovf", int'(acc_ovf), 0);
        check_eq("rst_lost", int'(frame_lost), 0);
        rst_n = 1'b1;
        acc_ready = 1'b1;
        repeat (4) issue(2, 3);
        wait_valid("rst_next", lat);
        check_eq("rst_next_data", int'($signed(acc_data)), 24);
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
